// File: rtl/intt_flat_pkg.sv
// Shared constants for the 16-point inverse NTT modulo 65537.
// It also holds the compile-time twiddle table and an index bit-reversal helper.
package intt_flat_pkg;

  localparam int CW = 17;
  localparam logic [CW-1:0] Q    = 17'd65537;
  localparam logic [CW-1:0] WINV = 17'd49153;
  localparam int unsigned NINV_DEF = 61441;
  localparam int LOG2D = 4;
  localparam int NTW   = 8;

  // WINV^k mod Q for k = 0..7; WINV = -2^14, so every entry is a signed power of two.
  localparam logic [CW-1:0] TW [NTW] = '{
    17'd1, 17'd49153, 17'd61441, 17'd64513,
    17'd65281, 17'd65473, 17'd65521, 17'd65533
  };

  function automatic int unsigned bitrev(input int unsigned v, input int unsigned bits);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < bits; i++) begin
      r = (r << 1) | ((v >> i) & 1);
    end
    return r;
  endfunction

endpackage

// File: rtl/intt_butterfly.sv
// Combinational Gentleman-Sande butterfly: sum = x+y, dif = (x-y)*w, all mod Q = 2^(N-1)+1.
module intt_butterfly #(
  parameter int N = 17
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic [N-1:0] w,
  output logic [N-1:0] sum,
  output logic [N-1:0] dif
);

  localparam logic signed [N+1:0] QS = {3'b001, {(N-2){1'b0}}, 1'b1};

  function automatic logic [N-1:0] mod_add(input logic [N-1:0] p, input logic [N-1:0] q);
    logic [N:0] s;
    s = {1'b0, p} + {1'b0, q};
    if (s >= QS[N:0]) s = s - QS[N:0];
    return s[N-1:0];
  endfunction

  function automatic logic [N-1:0] mod_sub(input logic [N-1:0] p, input logic [N-1:0] q);
    logic signed [N+1:0] d;
    d = $signed({2'b00, p}) - $signed({2'b00, q});
    if (d < 0) d = d + QS;
    return d[N-1:0];
  endfunction

  // 2^(N-1) == -1 mod Q, so the product folds as low half minus high half.
  function automatic logic [N-1:0] mod_mul(input logic [N-1:0] p, input logic [N-1:0] q);
    logic [2*N-1:0] m;
    logic signed [N+1:0] r;
    m = p * q;
    r = $signed({3'b000, m[N-2:0]}) - $signed({1'b0, m[2*N-1:N-1]});
    if (r < 0) r = r + QS;
    return r[N-1:0];
  endfunction

  assign sum = mod_add(x, y);
  assign dif = mod_mul(mod_sub(x, y), w);

endmodule

// File: rtl/intt_flat.sv
// Fully pipelined 16-point inverse NTT mod 65537: four registered GS stages, then registered
// scaling by D^-1.

module intt_flat
  import intt_flat_pkg::*;
#(
  parameter int N = 17,
  parameter int D = 16,
  parameter int unsigned NINV = NINV_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [D*N-1:0] a,
  output logic [D*N-1:0] b
);

  localparam logic signed [N+1:0] QS     = {3'b001, {(N-2){1'b0}}, 1'b1};
  localparam logic [N-1:0]        NINV_C = N'(NINV);

  function automatic logic [N-1:0] mod_mul(input logic [N-1:0] p, input logic [N-1:0] q);
    logic [2*N-1:0] m;
    logic signed [N+1:0] r;
    m = p * q;
    r = $signed({3'b000, m[N-2:0]}) - $signed({1'b0, m[2*N-1:N-1]});
    if (r < 0) r = r + QS;
    return r[N-1:0];
  endfunction

  logic [N-1:0] res   [LOG2D][D];
  logic [N-1:0] stg_p [LOG2D][D];
  logic [N-1:0] scl          [D];
  logic [N-1:0] scl_p        [D];

  // Stage s pairs elements D>>(s+1) apart; twiddle exponent is j*2^s (decimation in frequency).
  for (genvar s = 0; s < LOG2D; s++) begin : g_stage
    localparam int HALF = D >> (s + 1);
    for (genvar i = 0; i < D/2; i++) begin : g_bf
      localparam int J   = i % HALF;
      localparam int TOP = (i / HALF) * 2 * HALF + J;
      localparam int BOT = TOP + HALF;
      localparam int TWI = J << s;
      if (s == 0) begin : g_in
        intt_butterfly #(.N(N)) u_bf (
          .x   (a[N*TOP +: N]),
          .y   (a[N*BOT +: N]),
          .w   (N'(TW[TWI])),
          .sum (res[s][TOP]),
          .dif (res[s][BOT])
        );
      end else begin : g_mid
        intt_butterfly #(.N(N)) u_bf (
          .x   (stg_p[s-1][TOP]),
          .y   (stg_p[s-1][BOT]),
          .w   (N'(TW[TWI])),
          .sum (res[s][TOP]),
          .dif (res[s][BOT])
        );
      end
    end
  end

  // Last GS stage leaves results in bit-reversed order; undo it while scaling.
  for (genvar j = 0; j < D; j++) begin : g_scale
    localparam int R = bitrev(j, LOG2D);
    assign scl[j]        = mod_mul(stg_p[LOG2D-1][R], NINV_C);
    assign b[N*j +: N]   = scl_p[j];
  end

  // ---- stage boundary: butterfly registers p1..p4, scaled output p5 ----
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < LOG2D; s++) begin
        for (int k = 0; k < D; k++) begin
          stg_p[s][k] <= '0;
        end
      end
      for (int k = 0; k < D; k++) begin
        scl_p[k] <= '0;
      end
    end else begin
      for (int s = 0; s < LOG2D; s++) begin
        for (int k = 0; k < D; k++) begin
          stg_p[s][k] <= res[s][k];
        end
      end
      for (int k = 0; k < D; k++) begin
        scl_p[k] <= scl[k];
      end
    end
  end

endmodule

// File: tb/tb_intt_flat.sv
// Directed and random checks of intt_flat against hand values and a direct-sum INTT model.
module tb_intt_flat;
  import intt_flat_pkg::*;

  localparam int N = 17;
  localparam int D = 16;
  localparam int W = N * D;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] a;
  logic [W-1:0] b;

  int n_cmp;
  int n_err;

  intt_flat #(.N(N), .D(D), .NINV(NINV_DEF)) dut (
    .clk (clk),
    .rst (rst),
    .a   (a),
    .b   (b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] splat(input int unsigned val);
    logic [W-1:0] r;
    for (int k = 0; k < D; k++) r[N*k +: N] = val[N-1:0];
    return r;
  endfunction

  function automatic logic [W-1:0] one(input int idx, input int unsigned val);
    logic [W-1:0] r;
    r = '0;
    r[N*idx +: N] = val[N-1:0];
    return r;
  endfunction

  // Direct O(D^2) evaluation of NINV * sum a[i]*WINV^(i*j) mod Q.
  function automatic logic [W-1:0] ref_intt(input logic [W-1:0] v);
    logic [W-1:0] r;
    longint unsigned acc, tw, ai;
    r = '0;
    for (int j = 0; j < D; j++) begin
      acc = 0;
      for (int i = 0; i < D; i++) begin
        tw = 1;
        for (int e = 0; e < ((i * j) % D); e++) tw = (tw * WINV) % Q;
        ai  = v[N*i +: N];
        acc = (acc + ai * tw) % Q;
      end
      acc = (acc * NINV_DEF) % Q;
      r[N*j +: N] = acc[N-1:0];
    end
    return r;
  endfunction

  logic [W-1:0] vin[$];
  logic [W-1:0] vexp[$];
  string        vtag[$];

  initial begin
    int unsigned sd[16] = '{61441, 64513, 65281, 65473, 65521, 65533, 65536, 16384,
                            4096, 1024, 256, 64, 16, 4, 1, 49153};
    logic [W-1:0] v;
    logic [W-1:0] sd_exp;
    int nv;

    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    a   = '0;
    repeat (2) @(negedge clk);
    chk("reset_b", b, '0);
    a = splat(1234);
    @(negedge clk);
    chk("reset_hold", b, '0);
    a   = '0;
    rst = 1'b0;

    for (int j = 0; j < D; j++) sd_exp[N*j +: N] = sd[j][N-1:0];

    vin.push_back('0);            vexp.push_back('0);               vtag.push_back("zero");
    vin.push_back(one(0, 1));     vexp.push_back(splat(61441));     vtag.push_back("delta");
    vin.push_back(splat(1));      vexp.push_back(one(0, 1));        vtag.push_back("const1");
    vin.push_back(one(1, 1));     vexp.push_back(sd_exp);           vtag.push_back("shift_delta");
    vin.push_back(splat(65536));  vexp.push_back(one(0, 65536));    vtag.push_back("const_m1");
    for (int r = 0; r < 20; r++) begin
      for (int k = 0; k < D; k++) v[N*k +: N] = N'($urandom_range(0, 65536));
      if (r == 0) v[N*3 +: N] = 17'd65536;
      vin.push_back(v);
      vexp.push_back(ref_intt(v));
      vtag.push_back($sformatf("rand%0d", r));
    end
    nv = vin.size();

    // Back-to-back stream; result for input k appears 5 cycles later.
    for (int k = 0; k < nv + 5; k++) begin
      @(negedge clk);
      if (k < 5) chk($sformatf("pre%0d", k), b, '0);
      else       chk(vtag[k-5], b, vexp[k-5]);
      a = (k < nv) ? vin[k] : '0;
    end

    @(negedge clk); a = one(0, 1);
    @(negedge clk); a = splat(1);
    @(negedge clk); a = one(1, 1);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    chk("midrst", b, '0);
    rst = 1'b0;
    a   = one(0, 1);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      a = '0;
      if (k == 5) chk("post_rst_delta", b, splat(61441));
      else        chk($sformatf("post_rst%0d", k), b, '0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
